// File: rtl/mul_arbiter_if.sv
// mul_arbiter_if
//   Bundles the requester-side and multiplier-side signals of mul_arbiter.
//   slave  : arbiter view (takes requests and multiplier results, drives grants/operands)
//   master : environment view (requesters plus the shared multiplier)
//   Signals:
//     req_valid/req_factor1/req_factor2/req_op  per-requester request, operands, MULop
//     req_ready/rsp_product                     per-requester done pulse, shared product
//     busy/grant_id                             arbiter status
//     mul_factor1/mul_factor2/mul_op/mul_valid  operands and valid to the multiplier
//     mul_ready/mul_product                     result handshake from the multiplier
interface mul_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
);
  localparam int unsigned IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*32-1:0] req_factor1;
  logic [NUM_REQ*32-1:0] req_factor2;
  logic [NUM_REQ*2-1:0]  req_op;
  logic [NUM_REQ-1:0]    req_ready;
  logic [31:0]           rsp_product;
  logic                  busy;
  logic [IDW-1:0]        grant_id;
  logic [31:0]           mul_factor1;
  logic [31:0]           mul_factor2;
  logic [1:0]            mul_op;
  logic                  mul_valid;
  logic                  mul_ready;
  logic [31:0]           mul_product;

  modport master (
    output req_valid, req_factor1, req_factor2, req_op, mul_ready, mul_product,
    input  req_ready, rsp_product, busy, grant_id,
           mul_factor1, mul_factor2, mul_op, mul_valid
  );

  modport slave (
    input  req_valid, req_factor1, req_factor2, req_op, mul_ready, mul_product,
    output req_ready, rsp_product, busy, grant_id,
           mul_factor1, mul_factor2, mul_op, mul_valid
  );
endinterface

// File: rtl/mul_arbiter.sv
// mul_arbiter
//   Round-robin arbiter sharing one rv32im multiplier among NUM_REQ requesters.
//   Grants one requester, latches its operands/op, holds mul_valid until the
//   multiplier's mul_ready pulse, then returns the product on rsp_product with a
//   one-cycle req_ready pulse for the granted requester. All outputs registered.
//   Ports:
//     clk    rising-edge clock
//     reset  synchronous active-high reset (aborts an outstanding op silently)
//     bus    mul_arbiter_if.slave: request bus, response bus, status, multiplier side
module mul_arbiter #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic         clk,
  input  logic         reset,
  mul_arbiter_if.slave bus
);
  localparam int unsigned IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t             r_state,       w_state_nxt;
  logic [IDW-1:0]     r_rr_ptr,      w_rr_ptr_nxt;
  logic [IDW-1:0]     r_grant_id,    w_grant_id_nxt;
  logic [NUM_REQ-1:0] r_req_ready,   w_req_ready_nxt;
  logic [31:0]        r_rsp_product, w_rsp_product_nxt;
  logic [31:0]        r_mul_factor1, w_mul_factor1_nxt;
  logic [31:0]        r_mul_factor2, w_mul_factor2_nxt;
  logic [1:0]         r_mul_op,      w_mul_op_nxt;
  logic               r_mul_valid,   w_mul_valid_nxt;
  logic               r_busy,        w_busy_nxt;

  logic [NUM_REQ-1:0] w_eligible;
  logic               w_found;
  logic [IDW-1:0]     w_winner;
  logic [IDW:0]       w_sum;
  logic [IDW-1:0]     w_cand;

  logic [31:0]        w_f1_arr [NUM_REQ];
  logic [31:0]        w_f2_arr [NUM_REQ];
  logic [1:0]         w_op_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_f1_arr[g] = bus.req_factor1[g*32 +: 32];
    assign w_f2_arr[g] = bus.req_factor2[g*32 +: 32];
    assign w_op_arr[g] = bus.req_op[g*2 +: 2];
  end

  // A requester being pulsed done this cycle still shows req_valid; mask it.
  assign w_eligible = bus.req_valid & ~r_req_ready;

  // First eligible index scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  always_comb begin : rr_search
    w_found  = 1'b0;
    w_winner = '0;
    w_sum    = '0;
    w_cand   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_sum = {1'b0, r_rr_ptr} + (IDW+1)'(k);
      if (w_sum >= (IDW+1)'(NUM_REQ)) begin
        w_sum = w_sum - (IDW+1)'(NUM_REQ);
      end
      w_cand = w_sum[IDW-1:0];
      if (!w_found && w_eligible[w_cand]) begin
        w_found  = 1'b1;
        w_winner = w_cand;
      end
    end
  end

  always_comb begin : fsm_next
    w_state_nxt       = r_state;
    w_rr_ptr_nxt      = r_rr_ptr;
    w_grant_id_nxt    = r_grant_id;
    w_req_ready_nxt   = '0;
    w_rsp_product_nxt = r_rsp_product;
    w_mul_factor1_nxt = r_mul_factor1;
    w_mul_factor2_nxt = r_mul_factor2;
    w_mul_op_nxt      = r_mul_op;
    w_mul_valid_nxt   = r_mul_valid;
    w_busy_nxt        = r_busy;

    case (r_state)
      IDLE: begin
        w_mul_valid_nxt = 1'b0;
        if (w_found) begin
          w_mul_factor1_nxt = w_f1_arr[w_winner];
          w_mul_factor2_nxt = w_f2_arr[w_winner];
          w_mul_op_nxt      = w_op_arr[w_winner];
          w_grant_id_nxt    = w_winner;
          w_mul_valid_nxt   = 1'b1;
          w_busy_nxt        = 1'b1;
          w_state_nxt       = BUSY;
        end
      end
      BUSY: begin
        // Operands stay frozen: the multiplier re-reads them in its last cycle.
        if (bus.mul_ready) begin
          w_rsp_product_nxt           = bus.mul_product;
          w_req_ready_nxt[r_grant_id] = 1'b1;
          w_mul_valid_nxt             = 1'b0;
          w_busy_nxt                  = 1'b0;
          w_rr_ptr_nxt = (r_grant_id == IDW'(NUM_REQ - 1)) ? '0 : r_grant_id + IDW'(1);
          w_state_nxt                 = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin : fsm_regs
    if (reset) begin
      r_state       <= IDLE;
      r_rr_ptr      <= '0;
      r_grant_id    <= '0;
      r_req_ready   <= '0;
      r_rsp_product <= '0;
      r_mul_factor1 <= '0;
      r_mul_factor2 <= '0;
      r_mul_op      <= '0;
      r_mul_valid   <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_rr_ptr      <= w_rr_ptr_nxt;
      r_grant_id    <= w_grant_id_nxt;
      r_req_ready   <= w_req_ready_nxt;
      r_rsp_product <= w_rsp_product_nxt;
      r_mul_factor1 <= w_mul_factor1_nxt;
      r_mul_factor2 <= w_mul_factor2_nxt;
      r_mul_op      <= w_mul_op_nxt;
      r_mul_valid   <= w_mul_valid_nxt;
      r_busy        <= w_busy_nxt;
    end
  end

  assign bus.req_ready   = r_req_ready;
  assign bus.rsp_product = r_rsp_product;
  assign bus.busy        = r_busy;
  assign bus.grant_id    = r_grant_id;
  assign bus.mul_factor1 = r_mul_factor1;
  assign bus.mul_factor2 = r_mul_factor2;
  assign bus.mul_op      = r_mul_op;
  assign bus.mul_valid   = r_mul_valid;
endmodule

// File: tb/tb_mul_arbiter.sv
// tb_mul_arbiter
//   Self-checking bench for mul_arbiter with NUM_REQ=4 and a 3-cycle multiplier
//   model. Expected grant order comes from a round-robin pick over the pending
//   set; expected products come from 64-bit arithmetic on the stimulus operands.
module tb_mul_arbiter;
  logic clk;
  logic reset;

  mul_arbiter_if #(.NUM_REQ(4)) bus ();

  mul_arbiter #(.NUM_REQ(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_chk  = 0;
  int cyc    = 0;
  int m_ptr  = 0;
  bit drop_mode = 1'b1;
  bit spur = 1'b0;

  logic [31:0] t_f1 [4];
  logic [31:0] t_f2 [4];
  logic [1:0]  t_op [4];

  logic [3:0]  evr [$];
  logic [31:0] evp [$];
  int          evc [$];

  function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] p;
    case (op)
      2'b01:   p = 64'($signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}));
      2'b10:   p = 64'($signed({{32{a[31]}}, a}) * $signed({32'b0, b}));
      default: p = {32'b0, a} * {32'b0, b};
    endcase
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  function automatic int rr_pick(input logic [3:0] pend, input int ptr);
    for (int k = 0; k < 4; k++) begin
      if (((pend >> ((ptr + k) % 4)) & 4'b0001) != 4'b0000) return (ptr + k) % 4;
    end
    return -1;
  endfunction

  // Multiplier model: mul_ready pulses on the 3rd cycle of a seen mul_valid.
  int unsigned m_cnt;
  always @(posedge clk) begin
    if (reset) begin
      bus.mul_ready   <= 1'b0;
      bus.mul_product <= '0;
      m_cnt           <= 0;
    end else if (spur) begin
      bus.mul_ready   <= 1'b1;
      bus.mul_product <= 32'hDEADBEEF;
    end else if (bus.mul_ready) begin
      bus.mul_ready <= 1'b0;
      m_cnt         <= 0;
    end else if (bus.mul_valid) begin
      if (m_cnt == 2) begin
        bus.mul_ready   <= 1'b1;
        bus.mul_product <= ref_mul(bus.mul_op, bus.mul_factor1, bus.mul_factor2);
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end
  end

  task automatic apply_ops();
    bus.req_factor1 = {t_f1[3], t_f1[2], t_f1[1], t_f1[0]};
    bus.req_factor2 = {t_f2[3], t_f2[2], t_f2[1], t_f2[0]};
    bus.req_op      = {t_op[3], t_op[2], t_op[1], t_op[0]};
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] op);
    t_f1[i] = a;
    t_f2[i] = b;
    t_op[i] = op;
    apply_ops();
  endtask

  task automatic clear_ev();
    evr.delete();
    evp.delete();
    evc.delete();
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    if (bus.req_ready !== 4'b0000) begin
      evr.push_back(bus.req_ready);
      evp.push_back(bus.rsp_product);
      evc.push_back(cyc);
      if (drop_mode) bus.req_valid = bus.req_valid & ~bus.req_ready;
    end
  endtask

  task automatic collect(input int n, input int budget);
    int k;
    k = 0;
    while (evr.size() < n && k < budget) begin
      step();
      k++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    n_chk++; if (bus.mul_valid !== 1'b0) $display("FAIL rst_mul_valid got %b want 0", bus.mul_valid); else n_pass++;
    n_chk++; if (bus.req_ready !== 4'b0000) $display("FAIL rst_req_ready got %b want 0000", bus.req_ready); else n_pass++;
    n_chk++; if (bus.rsp_product !== 32'h0) $display("FAIL rst_rsp got %h want 0", bus.rsp_product); else n_pass++;
    n_chk++; if (bus.busy !== 1'b0) $display("FAIL rst_busy got %b want 0", bus.busy); else n_pass++;
    n_chk++; if (bus.grant_id !== 2'd0) $display("FAIL rst_grant_id got %0d want 0", bus.grant_id); else n_pass++;
    n_chk++; if (bus.mul_factor1 !== 32'h0 || bus.mul_factor2 !== 32'h0)
      $display("FAIL rst_factors got %h/%h want 0/0", bus.mul_factor1, bus.mul_factor2); else n_pass++;
    n_chk++; if (bus.mul_op !== 2'b00) $display("FAIL rst_mul_op got %b want 00", bus.mul_op); else n_pass++;
    reset = 1'b0;
    m_ptr = 0;
    step();
  endtask

  task automatic test_basic();
    int c0;
    clear_ev();
    set_req(0, 32'd7, 32'd6, 2'b00);
    bus.req_valid = 4'b0001;
    c0 = cyc;
    step();
    n_chk++; if (bus.mul_valid !== 1'b1) $display("FAIL basic_mul_valid got %b want 1", bus.mul_valid); else n_pass++;
    n_chk++; if (bus.busy !== 1'b1) $display("FAIL basic_busy got %b want 1", bus.busy); else n_pass++;
    n_chk++; if (bus.mul_factor1 !== 32'd7 || bus.mul_factor2 !== 32'd6 || bus.mul_op !== 2'b00)
      $display("FAIL basic_operands got %h/%h/%b want 7/6/00", bus.mul_factor1, bus.mul_factor2, bus.mul_op); else n_pass++;
    collect(1, 20);
    n_chk++; if (evr.size() != 1) $display("FAIL basic_done_count got %0d want 1", evr.size()); else n_pass++;
    if (evr.size() == 1) begin
      n_chk++; if (evr[0] !== 4'b0001) $display("FAIL basic_req_ready got %b want 0001", evr[0]); else n_pass++;
      n_chk++; if (evp[0] !== 32'd42) $display("FAIL basic_rsp got %0d want 42", evp[0]); else n_pass++;
      n_chk++; if (evc[0] != c0 + 5) $display("FAIL basic_latency got %0d want %0d", evc[0] - c0, 5); else n_pass++;
      n_chk++; if (bus.mul_valid !== 1'b0 || bus.busy !== 1'b0)
        $display("FAIL basic_idle_after got valid=%b busy=%b want 0/0", bus.mul_valid, bus.busy); else n_pass++;
    end
    m_ptr = 1;
    step();
    n_chk++; if (bus.req_ready !== 4'b0000) $display("FAIL basic_pulse_width got %b want 0000", bus.req_ready); else n_pass++;
  endtask

  task automatic test_spurious();
    clear_ev();
    spur = 1'b1;
    step();
    spur = 1'b0;
    repeat (4) begin
      step();
      n_chk++; if (bus.busy !== 1'b0 || bus.mul_valid !== 1'b0)
        $display("FAIL spur_idle got busy=%b valid=%b want 0/0", bus.busy, bus.mul_valid); else n_pass++;
    end
    n_chk++; if (evr.size() != 0) $display("FAIL spur_no_done got %0d pulses want 0", evr.size()); else n_pass++;
    n_chk++; if (bus.rsp_product !== 32'd42) $display("FAIL spur_rsp_held got %h want 0000002a", bus.rsp_product); else n_pass++;
  endtask

  task automatic test_ops();
    logic [1:0]  ops [3];
    logic [31:0] want [3];
    ops[0] = 2'b01; want[0] = 32'h00000000;
    ops[1] = 2'b11; want[1] = 32'hFFFFFFFE;
    ops[2] = 2'b10; want[2] = 32'hFFFFFFFF;
    for (int i = 0; i < 3; i++) begin
      clear_ev();
      set_req(1, 32'hFFFFFFFF, 32'hFFFFFFFF, ops[i]);
      bus.req_valid = 4'b0010;
      collect(1, 20);
      n_chk++; if (evr.size() != 1) $display("FAIL ops_done_count op=%b got %0d want 1", ops[i], evr.size()); else n_pass++;
      if (evr.size() == 1) begin
        n_chk++; if (evr[0] !== 4'b0010) $display("FAIL ops_req_ready op=%b got %b want 0010", ops[i], evr[0]); else n_pass++;
        n_chk++; if (evp[0] !== want[i]) $display("FAIL ops_rsp op=%b got %h want %h", ops[i], evp[0], want[i]); else n_pass++;
      end
      step();
    end
    m_ptr = 2;
  endtask

  task automatic test_all_four();
    int c0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    m_ptr = 0;
    step();
    for (int i = 0; i < 4; i++) set_req(i, $urandom, $urandom, 2'($urandom_range(0, 3)));
    clear_ev();
    bus.req_valid = 4'b1111;
    c0 = cyc;
    collect(4, 40);
    n_chk++; if (evr.size() != 4) $display("FAIL all4_done_count got %0d want 4", evr.size()); else n_pass++;
    for (int k = 0; k < evr.size() && k < 4; k++) begin
      n_chk++; if (evr[k] !== (4'b0001 << k)) $display("FAIL all4_order idx=%0d got %b want %b", k, evr[k], 4'b0001 << k); else n_pass++;
      n_chk++; if (evp[k] !== ref_mul(t_op[k], t_f1[k], t_f2[k]))
        $display("FAIL all4_rsp idx=%0d got %h want %h", k, evp[k], ref_mul(t_op[k], t_f1[k], t_f2[k])); else n_pass++;
      n_chk++; if (evc[k] != c0 + 5 * (k + 1)) $display("FAIL all4_timing idx=%0d got %0d want %0d", k, evc[k] - c0, 5 * (k + 1)); else n_pass++;
    end
    m_ptr = 0;
    step();
  endtask

  task automatic test_fair();
    int c0;
    int p;
    int w;
    set_req(0, 32'd1000, 32'd3, 2'b00);
    set_req(2, 32'hFFFFFFF0, 32'd2, 2'b10);
    clear_ev();
    drop_mode = 1'b0;
    bus.req_valid = 4'b0101;
    c0 = cyc;
    collect(6, 50);
    bus.req_valid = 4'b0000;
    drop_mode = 1'b1;
    n_chk++; if (evr.size() != 6) $display("FAIL fair_done_count got %0d want 6", evr.size()); else n_pass++;
    p = m_ptr;
    for (int k = 0; k < evr.size() && k < 6; k++) begin
      w = rr_pick(4'b0101, p);
      p = (w + 1) % 4;
      n_chk++; if (evr[k] !== (4'b0001 << w)) $display("FAIL fair_order idx=%0d got %b want %b", k, evr[k], 4'b0001 << w); else n_pass++;
      n_chk++; if (evp[k] !== ref_mul(t_op[w], t_f1[w], t_f2[w]))
        $display("FAIL fair_rsp idx=%0d got %h want %h", k, evp[k], ref_mul(t_op[w], t_f1[w], t_f2[w])); else n_pass++;
      n_chk++; if (evc[k] != c0 + 5 * (k + 1)) $display("FAIL fair_timing idx=%0d got %0d want %0d", k, evc[k] - c0, 5 * (k + 1)); else n_pass++;
      if (k > 0) begin
        n_chk++; if (evr[k] === evr[k-1]) $display("FAIL fair_repeat idx=%0d got %b twice want alternation", k, evr[k]); else n_pass++;
      end
    end
    m_ptr = p;
    step();
  endtask

  task automatic test_reset_midop();
    int c3;
    set_req(2, 32'h00001234, 32'h00000010, 2'b00);
    clear_ev();
    bus.req_valid = 4'b0100;
    step();
    step();
    n_chk++; if (bus.busy !== 1'b1) $display("FAIL rmid_busy_before got %b want 1", bus.busy); else n_pass++;
    reset = 1'b1;
    step();
    reset = 1'b0;
    m_ptr = 0;
    c3 = cyc;
    n_chk++; if (bus.mul_valid !== 1'b0 || bus.busy !== 1'b0)
      $display("FAIL rmid_abort got valid=%b busy=%b want 0/0", bus.mul_valid, bus.busy); else n_pass++;
    n_chk++; if (evr.size() != 0) $display("FAIL rmid_no_pulse got %0d pulses want 0", evr.size()); else n_pass++;
    collect(1, 20);
    n_chk++; if (evr.size() != 1) $display("FAIL rmid_done_count got %0d want 1", evr.size()); else n_pass++;
    if (evr.size() == 1) begin
      n_chk++; if (evr[0] !== 4'b0100) $display("FAIL rmid_req_ready got %b want 0100", evr[0]); else n_pass++;
      n_chk++; if (evp[0] !== 32'h00012340) $display("FAIL rmid_rsp got %h want 00012340", evp[0]); else n_pass++;
      n_chk++; if (evc[0] != c3 + 5) $display("FAIL rmid_timing got %0d want 5", evc[0] - c3); else n_pass++;
    end
    m_ptr = 3;
    step();
  endtask

  task automatic test_latch();
    int k;
    set_req(3, 32'd3, 32'd5, 2'b00);
    clear_ev();
    bus.req_valid = 4'b1000;
    step();
    n_chk++; if (bus.mul_valid !== 1'b1) $display("FAIL latch_grant got %b want 1", bus.mul_valid); else n_pass++;
    set_req(3, 32'd0, 32'd0, 2'b00);
    k = 0;
    while (evr.size() == 0 && k < 12) begin
      if (bus.busy === 1'b1) begin
        n_chk++; if (bus.mul_factor1 !== 32'd3 || bus.mul_factor2 !== 32'd5)
          $display("FAIL latch_stable got %0d/%0d want 3/5", bus.mul_factor1, bus.mul_factor2); else n_pass++;
      end
      step();
      k++;
    end
    n_chk++; if (evr.size() != 1) $display("FAIL latch_done_count got %0d want 1", evr.size()); else n_pass++;
    if (evr.size() == 1) begin
      n_chk++; if (evr[0] !== 4'b1000) $display("FAIL latch_req_ready got %b want 1000", evr[0]); else n_pass++;
      n_chk++; if (evp[0] !== 32'd15) $display("FAIL latch_rsp got %0d want 15", evp[0]); else n_pass++;
    end
    m_ptr = 0;
    step();
  endtask

  task automatic test_random();
    logic [3:0] mask;
    logic [3:0] pend;
    int exp_id [$];
    int p;
    int w;
    int c0;
    for (int r = 0; r < 12; r++) begin
      mask = 4'($urandom_range(1, 15));
      for (int i = 0; i < 4; i++) set_req(i, $urandom, $urandom, 2'($urandom_range(0, 3)));
      exp_id.delete();
      pend = mask;
      p = m_ptr;
      while (pend != 4'b0000) begin
        w = rr_pick(pend, p);
        exp_id.push_back(w);
        pend = pend & ~(4'b0001 << w);
        p = (w + 1) % 4;
      end
      clear_ev();
      bus.req_valid = mask;
      c0 = cyc;
      collect(exp_id.size(), 5 * exp_id.size() + 10);
      n_chk++; if (evr.size() != exp_id.size())
        $display("FAIL rand_done_count round=%0d got %0d want %0d", r, evr.size(), exp_id.size()); else n_pass++;
      for (int k = 0; k < evr.size() && k < exp_id.size(); k++) begin
        w = exp_id[k];
        n_chk++; if (evr[k] !== (4'b0001 << w))
          $display("FAIL rand_order round=%0d idx=%0d got %b want %b", r, k, evr[k], 4'b0001 << w); else n_pass++;
        n_chk++; if (evp[k] !== ref_mul(t_op[w], t_f1[w], t_f2[w]))
          $display("FAIL rand_rsp round=%0d idx=%0d got %h want %h", r, k, evp[k], ref_mul(t_op[w], t_f1[w], t_f2[w])); else n_pass++;
        n_chk++; if (evc[k] != c0 + 5 * (k + 1))
          $display("FAIL rand_timing round=%0d idx=%0d got %0d want %0d", r, k, evc[k] - c0, 5 * (k + 1)); else n_pass++;
      end
      m_ptr = p;
      bus.req_valid = 4'b0000;
      repeat (1 + $urandom_range(0, 2)) step();
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.req_valid = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      t_f1[i] = '0;
      t_f2[i] = '0;
      t_op[i] = '0;
    end
    apply_ops();
    test_reset();
    test_basic();
    test_spurious();
    test_ops();
    test_all_four();
    test_fair();
    test_reset_midop();
    test_latch();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
